// File: rtl/instr_fetch_unit.sv
// IF stage: holds the PC, issues single-outstanding word reads to instruction
// memory, and fills the IF/ID register, honouring stalls and branch redirects.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic [31:0] r_hold_inst;
  logic [31:0] r_if_id_inst;
  logic [31:0] r_if_id_pc4;
  logic        r_if_id_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic        w_accept;
  logic        w_load;
  logic [31:0] w_load_inst;
  logic [31:0] w_redirect_pc;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = redirect_target & ~32'h3;
  // A correct-path response arrives only in S_WAIT with no pending discard.
  assign w_accept      = (r_state == S_WAIT) && imem_valid && !r_drop;
  assign w_load        = !redirect && !stall && (w_accept || (r_state == S_HOLD));
  assign w_load_inst   = (r_state == S_HOLD) ? r_hold_inst : imem_rdata;

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign if_id_inst  = r_if_id_inst;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;
  assign fetch_count = r_fetch_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_RESET & ~32'h3;
      r_drop        <= 1'b0;
      r_if_id_inst  <= 32'h0;
      r_if_id_pc4   <= 32'h0;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= 32'h0;
    end else if (redirect) begin
      r_pc          <= w_redirect_pc;
      r_if_id_inst  <= 32'h0;
      r_if_id_valid <= 1'b0;
      // A request to the old PC still outstanding must have its response swallowed.
      if ((r_state == S_REQ) || ((r_state == S_WAIT) && !imem_valid)) begin
        r_state <= S_WAIT;
        r_drop  <= 1'b1;
      end else begin
        r_state <= S_REQ;
        r_drop  <= 1'b0;
      end
    end else begin
      if (w_load) begin
        r_if_id_inst  <= w_load_inst;
        r_if_id_pc4   <= w_pc_plus4;
        r_if_id_valid <= 1'b1;
        r_pc          <= w_pc_plus4;
        r_fetch_count <= r_fetch_count + 32'd1;
      end else if (!stall) begin
        r_if_id_inst  <= 32'h0;
        r_if_id_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ:  r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else if (stall) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_HOLD: if (!stall) r_state <= S_REQ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Parked word is pure data; its validity is carried by r_state == S_HOLD.
  always_ff @(posedge clk) begin
    if (!redirect && w_accept && stall)
      r_hold_inst <= imem_rdata;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change 1 time unit after each
// rising edge, outputs are checked just after that edge.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int checks;
  int failures;

  instr_fetch_unit #(.PC_RESET(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_id_inst      (if_id_inst),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst,
                          input logic [31:0] pc4, input logic vld);
    chk({tag, "_inst"},  if_id_inst, inst);
    chk({tag, "_pc4"},   if_id_pc4, pc4);
    chk({tag, "_valid"}, {31'h0, if_id_valid}, {31'h0, vld});
  endtask

  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] cnt);
    chk({tag, "_req"},   {31'h0, imem_req}, {31'h0, req});
    chk({tag, "_addr"},  imem_addr, addr);
    chk({tag, "_count"}, fetch_count, cnt);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;

    #1 reset = 1'b1;
    #1;
    chk_fetch("rst", 1'b0, 32'h0, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    step(); step();
    reset = 1'b0;

    // Two back-to-back fetches with one-cycle memory latency
    step();
    chk_fetch("first_req", 1'b1, 32'h0, 32'h0);
    step();
    chk("wait0_req", {31'h0, imem_req}, 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    imem_valid = 1'b0;
    chk_ifid("f0", 32'h2008_0005, 32'h4, 1'b1);
    chk_fetch("f0", 1'b1, 32'h4, 32'd1);
    step();
    chk_ifid("bubble0", 32'h0, 32'h4, 1'b0);
    imem_valid = 1'b1; imem_rdata = 32'h8D09_0004;
    step();
    imem_valid = 1'b0;
    chk_ifid("f1", 32'h8D09_0004, 32'h8, 1'b1);
    chk_fetch("f1", 1'b1, 32'h8, 32'd2);

    // Stall held three cycles while the word for pc 0x8 arrives
    step();
    stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h0000_0020;
    step();
    imem_valid = 1'b0;
    chk_ifid("hold0", 32'h0, 32'h8, 1'b0);
    chk_fetch("hold0", 1'b0, 32'h8, 32'd2);
    step();
    chk_fetch("hold1", 1'b0, 32'h8, 32'd2);
    step();
    chk_ifid("hold2", 32'h0, 32'h8, 1'b0);
    chk_fetch("hold2", 1'b0, 32'h8, 32'd2);
    stall = 1'b0;
    step();
    chk_ifid("unhold", 32'h0000_0020, 32'hC, 1'b1);
    chk_fetch("unhold", 1'b1, 32'hC, 32'd3);

    step();
    imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_valid = 1'b0;
    chk_ifid("f3", 32'h1111_1111, 32'h10, 1'b1);
    chk_fetch("f3", 1'b1, 32'h10, 32'd4);

    // Redirect to 0x40 while the 0x10 response is still outstanding (L=3)
    step();
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    chk_ifid("redir", 32'h0, 32'h10, 1'b0);
    chk_fetch("redir", 1'b0, 32'h40, 32'd4);
    step();
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_valid = 1'b0;
    chk_ifid("dropped", 32'h0, 32'h10, 1'b0);
    chk_fetch("dropped", 1'b1, 32'h40, 32'd4);

    step();
    imem_valid = 1'b1; imem_rdata = 32'h2222_2222;
    step();
    imem_valid = 1'b0;
    chk_ifid("f40", 32'h2222_2222, 32'h44, 1'b1);
    chk_fetch("f40", 1'b1, 32'h44, 32'd5);

    // Redirect and stall together with a misaligned target
    redirect = 1'b1; stall = 1'b1; redirect_target = 32'h103;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk_ifid("redir_stall", 32'h0, 32'h44, 1'b0);
    chk_fetch("redir_stall", 1'b0, 32'h100, 32'd5);
    imem_valid = 1'b1; imem_rdata = 32'h3333_3333;
    step();
    imem_valid = 1'b0;
    chk_ifid("drop44", 32'h0, 32'h44, 1'b0);
    chk_fetch("drop44", 1'b1, 32'h100, 32'd5);

    // Asynchronous reset mid-wait, then a stray response
    step();
    reset = 1'b1;
    #1;
    chk_fetch("arst", 1'b0, 32'h0, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    step();
    reset = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h4444_4444;
    step();
    imem_valid = 1'b0;
    chk_fetch("restart", 1'b1, 32'h0, 32'h0);
    chk_ifid("restart", 32'h0, 32'h0, 1'b0);

    // PC wrap: redirect to 0xFFFFFFFC as the 0x0 response lands
    step();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    imem_valid = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    redirect = 1'b0; imem_valid = 1'b0;
    chk_fetch("wrap_req", 1'b1, 32'hFFFF_FFFC, 32'h0);
    chk_ifid("wrap_req", 32'h0, 32'h0, 1'b0);
    step();
    imem_valid = 1'b1; imem_rdata = 32'h6666_6666;
    step();
    imem_valid = 1'b0;
    chk_ifid("wrap", 32'h6666_6666, 32'h0, 1'b1);
    chk_fetch("wrap", 1'b1, 32'h0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch (IF) stage for the pipelined MIPS core: the producer side of the instruction stream the control decoder consumes. It holds the PC, issues word reads to instruction memory over a single-outstanding request/valid interface, and loads fetched words into the IF/ID register. It also honours load-use stalls and branch/jump redirects from ID/EX, discarding any in-flight wrong-path response.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  one-cycle read request pulse.
- imem_addr  out  32  byte address of request; always equals current PC.
- imem_valid  in  1  response strobe, at least 1 cycle after imem_req; one per request.
- imem_rdata  in  32  instruction word, qualified by imem_valid.
- stall  in  1  hazard unit: hold IF/ID and PC.
- redirect  in  1  taken branch or jump; wins over stall.
- redirect_target  in  32  new PC; bits [1:0] forced to 0 internally.
- if_id_inst  out  32  instruction to decoder; bits [31:26] drive the opcode decode.
- if_id_pc4  out  32  PC+4 of if_id_inst.
- if_id_valid  out  1  if_id_inst is a real instruction.
- fetch_count  out  32  instructions delivered into IF/ID, wraps at 2^32.

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD. Internal: pc[31:0], drop flag, hold_inst[31:0].
- S_IDLE: entered only from reset; unconditionally -> S_REQ next cycle.
- S_REQ: imem_req=1 (combinational from state), imem_addr=pc; -> S_WAIT.
- S_WAIT, imem_valid=1, drop=0:
  - if stall=0: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; fetch_count+1; -> S_REQ.
  - if stall=1: hold_inst <= imem_rdata; -> S_HOLD.
- S_WAIT, imem_valid=1, drop=1: discard word; drop <= 0; -> S_REQ.
- S_HOLD: when stall=0, IF/ID <= {hold_inst, pc+4, 1}; pc <= pc+4; fetch_count+1; -> S_REQ.
- IF/ID when stall=0 and no load this cycle: bubble, if_id_inst <= 32'h0, if_id_valid <= 0, if_id_pc4 unchanged.
- IF/ID when stall=1: all three fields hold.
- redirect=1 (any state, regardless of stall):
  - pc <= {redirect_target[31:2], 2'b00}; IF/ID <= bubble; hold_inst discarded.
  - S_IDLE, S_HOLD, or S_WAIT with imem_valid=1 this cycle: -> S_REQ, drop <= 0.
  - S_REQ (request to old PC is issued this cycle) or S_WAIT with imem_valid=0: -> S_WAIT, drop <= 1.
  - fetch_count not incremented; the response to the old PC is never delivered.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0.
- imem_valid outside S_WAIT is a protocol error and is ignored.

## Timing
- Reset values: pc=PC_RESET, state=S_IDLE, drop=0, imem_req=0, imem_addr=PC_RESET, if_id_inst=0, if_id_pc4=0, if_id_valid=0, fetch_count=0.
- First imem_req: 1st rising edge after reset release enters S_REQ; imem_req is high during the following cycle.
- Memory latency L≥1 cycles after the imem_req cycle; IF/ID is loaded at the edge where imem_valid is sampled and is visible the next cycle.
- Throughput with L=1 and no stall: one instruction per 2 cycles.
- redirect to first correct-path imem_req: 1 cycle if no request is in flight; otherwise response cycle + 1.
- Reset asserted mid-request: outputs clear immediately. Any later imem_valid for the aborted request lands in S_IDLE or S_REQ and is ignored.

## Test plan
- Reset, PC_RESET=0, L=1, words 0x20080005, 0x8D090004, no stall: imem_addr 0x0 then 0x4. if_id_inst = 0x20080005 with pc4=0x4, then 0x8D090004 with pc4=0x8; fetch_count=2.
- stall held 3 cycles during the S_WAIT response of 0x00000020 at pc 0x8: S_HOLD entered, IF/ID and pc frozen. After stall drops, if_id_inst=0x00000020, pc4=0xC, next imem_addr=0xC.
- redirect to 0x40 while waiting (L=3) for pc 0x10: late word 0xDEADBEEF discarded, never on if_id_inst. Next imem_addr=0x40, if_id_valid=0 in between, fetch_count unchanged.
- redirect=1 and stall=1 together, redirect_target=0x103: pc becomes 0x100, IF/ID bubbled (inst=0, valid=0).
- Asynchronous reset pulse mid-S_WAIT: all outputs return to reset values without a clock edge. A subsequent stray imem_valid is ignored, and fetch restarts at PC_RESET.
- pc=0xFFFFFFFC fetch: if_id_pc4=0x0, next imem_addr=0x0.
